// File: rtl/delay_line_ctrl.sv
// Sequencer for the DEPTH-stage delay buffer: flush, fill, then compare live vs delayed signal.
// Optional build macro STAB_VIOL_CNT_EN enables the saturating mismatch counter on viol_cnt.
module delay_line_ctrl #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned STAB_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sig_in,
  input  logic             buf_lsb,
  output logic             buf_rst,
  output logic             buf_din,
  output logic             busy,
  output logic             out_valid,
  output logic             delayed_sig,
  output logic [CNT_W-1:0] stable_cnt,
  output logic             stable,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int unsigned FW = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0]    FILL_LAST = FW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] THR       = CNT_W'(STAB_THR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             match;

  assign match = (sig_in == buf_lsb);

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    stable_cnt_d = stable_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d      = S_FILL;
        fill_cnt_d   = '0;
        stable_cnt_d = '0;
      end
      S_FILL: begin
        fill_cnt_d = fill_cnt_q + FW'(1);
        if (fill_cnt_q == FILL_LAST) state_d = S_RUN;
        if (start) state_d = S_FLUSH;
      end
      S_RUN: begin
        if (!match)                   stable_cnt_d = '0;
        else if (stable_cnt_q != '1)  stable_cnt_d = stable_cnt_q + CNT_W'(1);
        if (start) state_d = S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
    // stop overrides any pending restart or progression
    if (stop) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fill_cnt_q   <= '0;
      stable_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

`ifdef STAB_VIOL_CNT_EN
  logic [CNT_W-1:0] viol_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == S_FLUSH) begin
      viol_cnt_q <= '0;
    end else if (state_q == S_RUN && !match && viol_cnt_q != '1) begin
      viol_cnt_q <= viol_cnt_q + CNT_W'(1);
    end
  end

  assign viol_cnt = viol_cnt_q;
`else
  assign viol_cnt = '0;
`endif

  assign buf_rst     = (state_q == S_IDLE) || (state_q == S_FLUSH);
  assign buf_din     = ((state_q == S_FILL) || (state_q == S_RUN)) ? sig_in : 1'b0;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_RUN);
  assign delayed_sig = (state_q == S_RUN) ? buf_lsb : 1'b0;
  assign stable_cnt  = stable_cnt_q;
  // held count is visible after stop, but stable only qualifies a live comparison
  assign stable      = (state_q == S_RUN) && (stable_cnt_q >= THR);

endmodule
